// File: rtl/spi_target.sv
// SPI mode-0 target port: oversamples SCK/CS/MOSI in clk and exchanges bytes
// with the core through a valid/rd receive and wr/busy transmit handshake.
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       wr,
  input  logic [7:0] tx_data,
  output logic       busy,
  input  logic       rd,
  output logic [7:0] rx_data,
  output logic       valid,
  output logic       overrun,
  output logic       active
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;
  logic                   sck_rise, sck_fall, cs_rise, cs_fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_sh, tx_sh, hold;
  logic [7:0]             rx_next, load_byte;
  logic                   load_tx, shift_tx, capture, byte_done, clear_cnt;

  // Synchroniser chains idle at the deselected bus state so reset never looks like a CS edge
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      sck_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_sync[SYNC_STAGES-1];
      cs_d      <= cs_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= IDLE;
    else         state <= state_next;
  end

  // Deselect wins over any sck edge landing in the same cycle
  always_comb begin
    state_next = state;
    load_tx    = 1'b0;
    shift_tx   = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = SHIFT;
          load_tx    = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_next = IDLE;
        end else begin
          capture = sck_rise;
          if (sck_fall) begin
            if (bit_cnt == 3'd0) load_tx = 1'b1;
            else                 shift_tx = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign clear_cnt = (state != state_next);
  assign rx_next   = {rx_sh[6:0], mosi_s};
  assign byte_done = capture && (bit_cnt == 3'd7);
  assign load_byte = busy ? hold : IDLE_BYTE;
  assign miso_oe   = (state == SHIFT);
  assign active    = (state == SHIFT);

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      bit_cnt <= 3'd0;
      rx_sh   <= 8'h00;
      rx_data <= 8'h00;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (clear_cnt) begin
        bit_cnt <= 3'd0;
        rx_sh   <= 8'h00;
      end else if (capture) begin
        bit_cnt <= bit_cnt + 3'd1;
        rx_sh   <= rx_next;
      end
      if (byte_done) begin
        rx_data <= rx_next;
        valid   <= 1'b1;
        if (valid && !rd) overrun <= 1'b1;
        else if (rd)      overrun <= 1'b0;
      end else if (rd) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  // A wr coinciding with a load: the old hold byte goes to the shifter, the new one stays pending
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      tx_sh <= 8'h00;
      hold  <= 8'h00;
      busy  <= 1'b0;
      miso  <= 1'b0;
    end else begin
      if (load_tx) begin
        tx_sh <= load_byte;
        miso  <= load_byte[7];
      end else if (shift_tx) begin
        tx_sh <= {tx_sh[6:0], 1'b0};
        miso  <= tx_sh[6];
      end
      if (wr) begin
        hold <= tx_data;
        busy <= 1'b1;
      end else if (load_tx) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a bit-banged SPI host at clk/8 plus
// hand-computed expectations for each handshake scenario.
module tb_spi_target;

  logic       clk;
  logic       resetq;
  logic       sck, cs_n, mosi;
  logic       miso, miso_oe;
  logic       wr, rd;
  logic [7:0] tx_data;
  logic       busy;
  logic [7:0] rx_data;
  logic       valid, overrun, active;

  int total = 0;
  int bad   = 0;

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
    .clk     (clk),
    .resetq  (resetq),
    .sck     (sck),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .miso_oe (miso_oe),
    .wr      (wr),
    .tx_data (tx_data),
    .busy    (busy),
    .rd      (rd),
    .rx_data (rx_data),
    .valid   (valid),
    .overrun (overrun),
    .active  (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mode-0 bit: data set while sck low, host samples miso just before the rise
  task automatic spi_bit(input logic b, output logic got);
    mosi = b;
    wait_clk(4);
    got = miso;
    sck = 1'b1;
    wait_clk(4);
    sck = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] out_byte, output logic [7:0] in_byte);
    logic g;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(out_byte[i], g);
      in_byte[i] = g;
    end
    wait_clk(4);
  endtask

  task automatic cs_select();
    cs_n = 1'b0;
    wait_clk(4);
  endtask

  task automatic cs_deselect();
    cs_n = 1'b1;
    wait_clk(4);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    wait_clk(1);
    rd = 1'b0;
    wait_clk(1);
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    tx_data = d;
    wr = 1'b1;
    wait_clk(1);
    wr = 1'b0;
    wait_clk(1);
  endtask

  task automatic test_reset();
    logic [7:0] flags;
    logic       g;
    resetq = 1'b0;
    #1;
    flags = {miso, miso_oe, busy, valid, overrun, active, 2'b00};
    total++;
    if (flags !== 8'h00 || rx_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_initial flags=%b rx_data=%h required flags=00000000 rx_data=00", flags, rx_data);
    end
    wait_clk(3);
    resetq = 1'b1;
    wait_clk(2);
    cs_select();
    for (int i = 0; i < 4; i++) spi_bit(1'b1, g);
    resetq = 1'b0;
    #1;
    flags = {miso, miso_oe, busy, valid, overrun, active, 2'b00};
    total++;
    if (flags !== 8'h00 || rx_data !== 8'h00) begin
      bad++;
      $display("[TB] FAIL reset_midbyte flags=%b rx_data=%h required flags=00000000 rx_data=00", flags, rx_data);
    end
    wait_clk(2);
    resetq = 1'b1;
    wait_clk(4);
    total++;
    if (miso_oe !== 1'b1 || miso !== 1'b1 || active !== 1'b1) begin
      bad++;
      $display("[TB] FAIL reset_reselect miso_oe=%b miso=%b active=%b required 1 1 1", miso_oe, miso, active);
    end
    cs_deselect();
    total++;
    if (miso_oe !== 1'b0 || active !== 1'b0 || valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_deselect miso_oe=%b active=%b valid=%b required 0 0 0", miso_oe, active, valid);
    end
  endtask

  task automatic test_receive();
    logic [7:0] pattern;
    logic [7:0] got;
    logic       g;
    pattern = 8'hA5;
    cs_select();
    for (int i = 7; i >= 1; i--) begin
      spi_bit(pattern[i], g);
      got[i] = g;
    end
    mosi = pattern[0];
    wait_clk(4);
    got[0] = miso;
    sck = 1'b1;
    wait_clk(2);
    total++;
    if (valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rx_latency_early valid=%b required 0", valid);
    end
    wait_clk(1);
    total++;
    if (valid !== 1'b1 || rx_data !== 8'hA5) begin
      bad++;
      $display("[TB] FAIL rx_byte valid=%b rx_data=%h required 1 a5", valid, rx_data);
    end
    wait_clk(1);
    sck = 1'b0;
    wait_clk(4);
    total++;
    if (got !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL rx_idle_miso got=%h required ff", got);
    end
    pulse_rd();
    total++;
    if (valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rx_rd_clear valid=%b overrun=%b required 0 0", valid, overrun);
    end
    cs_deselect();
  endtask

  task automatic test_transmit();
    logic [7:0] got;
    pulse_wr(8'h3C);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL tx_busy_set busy=%b required 1", busy);
    end
    cs_select();
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL tx_busy_at_cs busy=%b required 0", busy);
    end
    spi_xfer(8'h00, got);
    total++;
    if (got !== 8'h3C) begin
      bad++;
      $display("[TB] FAIL tx_byte got=%h required 3c", got);
    end
    spi_xfer(8'h00, got);
    total++;
    if (got !== 8'hFF) begin
      bad++;
      $display("[TB] FAIL tx_idle_byte got=%h required ff", got);
    end
    pulse_rd();
    cs_deselect();
  endtask

  task automatic test_last_write();
    logic [7:0] got;
    pulse_wr(8'h12);
    pulse_wr(8'h34);
    cs_select();
    spi_xfer(8'h00, got);
    total++;
    if (got !== 8'h34) begin
      bad++;
      $display("[TB] FAIL tx_last_write got=%h required 34", got);
    end
    pulse_rd();
    cs_deselect();
  endtask

  task automatic test_overrun();
    logic [7:0] got;
    cs_select();
    spi_xfer(8'h11, got);
    total++;
    if (valid !== 1'b1 || overrun !== 1'b0 || rx_data !== 8'h11) begin
      bad++;
      $display("[TB] FAIL ovr_first valid=%b overrun=%b rx_data=%h required 1 0 11", valid, overrun, rx_data);
    end
    spi_xfer(8'h22, got);
    total++;
    if (valid !== 1'b1 || overrun !== 1'b1 || rx_data !== 8'h22) begin
      bad++;
      $display("[TB] FAIL ovr_second valid=%b overrun=%b rx_data=%h required 1 1 22", valid, overrun, rx_data);
    end
    pulse_rd();
    total++;
    if (valid !== 1'b0 || overrun !== 1'b0) begin
      bad++;
      $display("[TB] FAIL ovr_rd_clear valid=%b overrun=%b required 0 0", valid, overrun);
    end
    cs_deselect();
  endtask

  task automatic test_abort();
    logic [7:0] got;
    logic       g;
    cs_select();
    for (int i = 0; i < 5; i++) spi_bit(1'b1, g);
    cs_deselect();
    total++;
    if (valid !== 1'b0 || active !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_partial valid=%b active=%b required 0 0", valid, active);
    end
    for (int i = 0; i < 8; i++) spi_bit(1'b1, g);
    wait_clk(4);
    total++;
    if (valid !== 1'b0 || miso_oe !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_sck_deselected valid=%b miso_oe=%b required 0 0", valid, miso_oe);
    end
    cs_select();
    spi_xfer(8'h81, got);
    total++;
    if (valid !== 1'b1 || rx_data !== 8'h81) begin
      bad++;
      $display("[TB] FAIL abort_next_byte valid=%b rx_data=%h required 1 81", valid, rx_data);
    end
    pulse_rd();
    cs_deselect();
  endtask

  task automatic test_simultaneous();
    logic [7:0] got;
    logic [7:0] pattern;
    logic       g;
    cs_select();
    spi_xfer(8'h5A, got);
    pattern = 8'hC3;
    for (int i = 7; i >= 1; i--) spi_bit(pattern[i], g);
    mosi = pattern[0];
    wait_clk(4);
    sck = 1'b1;
    wait_clk(2);
    rd = 1'b1;
    wait_clk(1);
    rd = 1'b0;
    total++;
    if (valid !== 1'b1 || overrun !== 1'b0 || rx_data !== 8'hC3) begin
      bad++;
      $display("[TB] FAIL sim_rd_complete valid=%b overrun=%b rx_data=%h required 1 0 c3", valid, overrun, rx_data);
    end
    wait_clk(1);
    sck = 1'b0;
    wait_clk(4);
    pulse_rd();
    cs_deselect();

    pulse_wr(8'hA1);
    cs_n = 1'b0;
    wait_clk(2);
    tx_data = 8'h4E;
    wr = 1'b1;
    wait_clk(1);
    wr = 1'b0;
    total++;
    if (busy !== 1'b1 || active !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sim_wr_load busy=%b active=%b required 1 1", busy, active);
    end
    wait_clk(2);
    spi_xfer(8'h00, got);
    total++;
    if (got !== 8'hA1) begin
      bad++;
      $display("[TB] FAIL sim_wr_old_byte got=%h required a1", got);
    end
    spi_xfer(8'h00, got);
    total++;
    if (got !== 8'h4E || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sim_wr_new_byte got=%h busy=%b required 4e 0", got, busy);
    end
    pulse_rd();
    cs_deselect();
  endtask

  initial begin
    resetq  = 1'b0;
    sck     = 1'b0;
    cs_n    = 1'b1;
    mosi    = 1'b0;
    wr      = 1'b0;
    rd      = 1'b0;
    tx_data = 8'h00;
    test_reset();
    test_receive();
    test_transmit();
    test_last_write();
    test_overrun();
    test_abort();
    test_simultaneous();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
